fp_conv_accum: RTL and testbench
================================

Name: fp_conv_accum

Overview:
- Sequential single-precision accumulator that sits directly downstream of the fp32 adder stage in the conv1 datapath.
- Consumes a stream of NUM_TERMS fp32 products for one output pixel (one kernel window) and adds them onto a bias.
- Emits one fp32 conv result per window through a valid/ready handshake, with optional ReLU.
- Each addition uses one combinational fadder instance; the operand guarding described under Behaviour keeps fadder inside its valid input range.

Parameters:
- NUM_TERMS, 25, products per output (5x5 kernel); legal range 1..255.
- RELU_EN, 1, when 1 a negative result is replaced by +0 (0x00000000) at output.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- bias  input  32  fp32 bias; sampled on the first accepted beat of each window.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block accepts in_data this cycle.
- in_data  input  32  fp32 product term.
- out_valid  output  1  out_data holds a finished result.
- out_ready  input  1  downstream accepts out_data.
- out_data  output  32  fp32 conv result.
- busy  output  1  high while a window is partially accumulated (cnt != 0) or a result is pending.

Behaviour:
- Reset (async, any state, including mid-window): state=IDLE, acc=0, cnt=0, out_valid=0, out_data=0, in_ready=0 while rst is high, busy=0. A partial window is discarded and not resumed.
- States: IDLE, ACCUM, OUT.
- A beat is accepted when in_valid && in_ready. in_ready=1 in IDLE and ACCUM; in_ready=0 in OUT.
- IDLE, beat accepted: acc <= addop(bias, in_data), cnt <= 1. Go to OUT if NUM_TERMS==1, else to ACCUM.
- ACCUM, beat accepted: acc <= addop(acc, in_data), cnt <= cnt+1. When this beat is beat NUM_TERMS, go to OUT and clear cnt to 0.
- No beat accepted (in_valid low): hold all state.
- OUT:
  - out_valid=1; out_data = (RELU_EN && acc[31]) ? 32'h0 : acc.
  - out_data stays stable while out_ready=0.
  - On out_valid && out_ready: go to IDLE, out_valid=0 next cycle.
- Latency: out_valid rises on the cycle after the last beat is accepted. One bubble cycle is enforced between windows, because in_ready is 0 in OUT.
- Throughput: one term per cycle in ACCUM. Total cost is NUM_TERMS+1 cycles per window at minimum.
- addop(x, y), single cycle, combinational:
  - A field exponent of 0 is treated as zero (denormals flushed).
  - If y is zero: result = x.
  - Else if x is zero: result = y.
  - Else if x[30:0]==y[30:0] and signs differ: result = +0 (fadder bypassed).
  - Else: present the operand with the larger magnitude (compare bits[30:0]) on fadder input A and the other on B; result = fadder.result.
- Inf, NaN and exponent overflow/underflow are out of scope; the result in those cases is undefined and is not checked.
- The bias is used exactly once per window. Changes to bias after the first beat have no effect on that window.

Test Plan:
- NUM_TERMS=4, RELU_EN=1, bias=0x00000000, in=0x3F800000, 0x40000000, 0x40400000, 0x40800000 on back-to-back cycles -> out_valid one cycle after the 4th beat, out_data=0x41200000 (10.0).
- bias=0x3F000000, four beats of 0x3F800000 with in_valid deasserted 2 cycles between beats -> out_data=0x40900000 (4.5); acc holds during the gaps.
- bias=0, in=0xBF800000, 0xC0000000, 0xC0400000, 0xC0800000 -> out_data=0x00000000 with RELU_EN=1; out_data=0xC1200000 with RELU_EN=0.
- bias=0, in=0x3F800000, 0xBF800000, 0x00000000, 0x40000000 (cancellation then zero) -> out_data=0x40000000 (2.0); simulation terminates with no hang.
- Backpressure: complete a window, hold out_ready=0 for 5 cycles -> out_valid=1, out_data stable, in_ready=0 throughout; out_ready=1 -> IDLE the next cycle, and the next window accumulates correctly.
- Assert rst after 2 of 4 beats -> out_valid=0, busy=0, out_data=0 immediately; a fresh full window after release yields the correct sum with no residue from the aborted window.

Source files
------------

// File: rtl/fp_conv_accum.sv
// Sequential fp32 accumulator: bias + NUM_TERMS products -> one result (optional ReLU),
// out_valid one cycle after the last beat; in_ready drops while a result waits for out_ready.

module fp_conv_fadder (
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] result
);
   // Expects |a| >= |b|, both nonzero normals, and not an exact cancellation.
   logic [7:0]  ea;
   logic [7:0]  eb;
   logic [7:0]  ediff;
   logic [26:0] ma_ext;
   logic [26:0] mb_ext;
   logic [26:0] mb_sh;
   logic [26:0] mask;
   logic [26:0] norm;
   logic [27:0] sum;
   logic [4:0]  lz;
   logic        found;
   logic [9:0]  exp_n;
   logic [24:0] mant_r;
   logic        rnd;

   always_comb begin
      ea     = a[30:23];
      eb     = b[30:23];
      ediff  = ea - eb;
      ma_ext = {1'b1, a[22:0], 3'b000};
      mb_ext = {1'b1, b[22:0], 3'b000};
      mask   = '0;
      mb_sh  = '0;
      sum    = '0;
      norm   = '0;
      lz     = '0;
      found  = 1'b0;
      exp_n  = {2'b00, ea};

      // Alignment shift keeps a sticky bit in the LSB for rounding.
      if (ediff > 8'd26) begin
         mb_sh = 27'd1;
      end else begin
         mask  = ~(27'h7ffffff << ediff);
         mb_sh = (mb_ext >> ediff) | {26'd0, |(mb_ext & mask)};
      end

      if (a[31] == b[31]) begin
         sum = {1'b0, ma_ext} + {1'b0, mb_sh};
         if (sum[27]) begin
            norm  = {sum[27:2], sum[1] | sum[0]};
            exp_n = {2'b00, ea} + 10'd1;
         end else begin
            norm  = sum[26:0];
         end
      end else begin
         sum = {1'b0, ma_ext} - {1'b0, mb_sh};
         for (int i = 26; i >= 0; i--) begin
            if (!found) begin
               if (sum[i]) found = 1'b1;
               else        lz    = lz + 5'd1;
            end
         end
         norm  = sum[26:0] << lz;
         exp_n = {2'b00, ea} - {5'd0, lz};
      end

      rnd    = norm[2] & (norm[1] | norm[0] | norm[3]);
      mant_r = {1'b0, norm[26:3]} + {24'd0, rnd};
      if (mant_r[24]) exp_n = exp_n + 10'd1;
      result = {a[31], exp_n[7:0], mant_r[22:0]};
   end
endmodule

module fp_conv_accum #(
   parameter int NUM_TERMS = 25,
   parameter int RELU_EN   = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] bias,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic        busy
);
   typedef enum logic [1:0] {IDLE, ACCUM, OUT} state_t;

   state_t      state_q, state_d;
   logic [31:0] acc_q, acc_d;
   logic [7:0]  cnt_q, cnt_d;

   logic [31:0] op_x;
   logic [31:0] op_y;
   logic        x_zero;
   logic        y_zero;
   logic [31:0] fa_a;
   logic [31:0] fa_b;
   logic [31:0] fa_res;
   logic [31:0] add_res;
   logic        accept;

   fp_conv_fadder u_fadder (
      .a      (fa_a),
      .b      (fa_b),
      .result (fa_res)
   );

   // Zero/cancellation guarding keeps the adder on nonzero, non-cancelling operands.
   always_comb begin
      op_x    = (state_q == IDLE) ? bias : acc_q;
      op_y    = in_data;
      x_zero  = (op_x[30:23] == 8'd0);
      y_zero  = (op_y[30:23] == 8'd0);
      fa_a    = op_x;
      fa_b    = op_y;
      if (op_x[30:0] < op_y[30:0]) begin
         fa_a = op_y;
         fa_b = op_x;
      end
      if (y_zero)                                           add_res = op_x;
      else if (x_zero)                                      add_res = op_y;
      else if (op_x[30:0] == op_y[30:0] && op_x[31] != op_y[31]) add_res = 32'h0;
      else                                                  add_res = fa_res;
   end

   assign in_ready  = ~rst && (state_q != OUT);
   assign out_valid = (state_q == OUT);
   assign out_data  = !out_valid                     ? 32'h0 :
                      (RELU_EN != 0 && acc_q[31])    ? 32'h0 : acc_q;
   assign busy      = (cnt_q != 8'd0) || out_valid;
   assign accept    = in_valid && in_ready;

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               acc_d = add_res;
               if (NUM_TERMS == 1) begin
                  state_d = OUT;
                  cnt_d   = 8'd0;
               end else begin
                  state_d = ACCUM;
                  cnt_d   = 8'd1;
               end
            end
         end
         ACCUM: begin
            if (accept) begin
               acc_d = add_res;
               if (cnt_q == 8'(NUM_TERMS - 1)) begin
                  state_d = OUT;
                  cnt_d   = 8'd0;
               end else begin
                  cnt_d   = cnt_q + 8'd1;
               end
            end
         end
         OUT: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         acc_q   <= 32'h0;
         cnt_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
      end
   end
endmodule

// File: tb/tb_fp_conv_accum.sv
// Bench for fp_conv_accum: 4-term ReLU/raw instances on shared inputs plus a 1-term instance.
module tb_fp_conv_accum;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] bias = 32'h0;
   logic        in_valid = 1'b0;
   logic [31:0] in_data = 32'h0;
   logic        out_ready = 1'b0;
   logic        in_valid1 = 1'b0;
   logic        out_ready1 = 1'b0;

   logic        in_ready_r, out_valid_r, busy_r;
   logic [31:0] out_data_r;
   logic        in_ready_w, out_valid_w, busy_w;
   logic [31:0] out_data_w;
   logic        in_ready_1, out_valid_1, busy_1;
   logic [31:0] out_data_1;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] relu;
      logic [31:0] raw;
   } exp_t;
   exp_t sb_q[$];

   always #5 clk = ~clk;

   fp_conv_accum #(.NUM_TERMS(4), .RELU_EN(1)) u_relu (
      .clk(clk), .rst(rst), .bias(bias), .in_valid(in_valid), .in_ready(in_ready_r),
      .in_data(in_data), .out_valid(out_valid_r), .out_ready(out_ready),
      .out_data(out_data_r), .busy(busy_r));

   fp_conv_accum #(.NUM_TERMS(4), .RELU_EN(0)) u_raw (
      .clk(clk), .rst(rst), .bias(bias), .in_valid(in_valid), .in_ready(in_ready_w),
      .in_data(in_data), .out_valid(out_valid_w), .out_ready(out_ready),
      .out_data(out_data_w), .busy(busy_w));

   fp_conv_accum #(.NUM_TERMS(1), .RELU_EN(0)) u_one (
      .clk(clk), .rst(rst), .bias(bias), .in_valid(in_valid1), .in_ready(in_ready_1),
      .in_data(in_data), .out_valid(out_valid_1), .out_ready(out_ready1),
      .out_data(out_data_1), .busy(busy_1));

   // Exact fp32 encoding of a small integer (|v| < 2^24).
   function automatic logic [31:0] int_to_fp(input int v);
      logic [31:0] m;
      logic [31:0] f;
      int          p;
      if (v == 0) return 32'h0;
      m = (v < 0) ? 32'(-v) : 32'(v);
      p = 0;
      for (int i = 0; i < 32; i++) if (m[i]) p = i;
      f = m << (23 - p);
      return {(v < 0), 8'(127 + p), f[22:0]};
   endfunction

   // Starts and ends on a falling edge; bias is scrambled after the first beat.
   task automatic drive_window(input logic [31:0] b, input logic [31:0] t [4], input int gap);
      int guard;
      guard = 0;
      while (!in_ready_r && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      for (int k = 0; k < 4; k++) begin
         bias     = (k == 0) ? b : 32'h4B00_1234;
         in_valid = 1'b1;
         in_data  = t[k];
         @(negedge clk);
         if (gap > 0 && k < 3) begin
            in_valid = 1'b0;
            in_data  = 32'h4120_0000;
            repeat (gap) @(negedge clk);
         end
      end
      in_valid = 1'b0;
      in_data  = 32'h0;
   endtask

   // lat = falling edges waited for out_valid, -1 if it never came.
   task automatic wait_valid(output int lat);
      lat = 0;
      while (!out_valid_r && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      if (!out_valid_r) lat = -1;
   endtask

   task automatic handshake();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++;
      if (out_valid_r !== 1'b0 || out_valid_w !== 1'b0 || out_valid_1 !== 1'b0) begin
         errors++; $display("FAIL reset_out_valid got %b%b%b want 000", out_valid_r, out_valid_w, out_valid_1);
      end
      checks++;
      if (in_ready_r !== 1'b0 || busy_r !== 1'b0) begin
         errors++; $display("FAIL reset_rdy_busy got in_ready=%b busy=%b want 0 0", in_ready_r, busy_r);
      end
      checks++;
      if (out_data_r !== 32'h0 || out_data_w !== 32'h0) begin
         errors++; $display("FAIL reset_out_data got %h %h want 0", out_data_r, out_data_w);
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (in_ready_r !== 1'b1 || busy_r !== 1'b0) begin
         errors++; $display("FAIL post_reset_idle got in_ready=%b busy=%b want 1 0", in_ready_r, busy_r);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] t [4];
      exp_t e;
      int lat;
      t = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000};
      sb_q.push_back('{relu: 32'h4120_0000, raw: 32'h4120_0000});
      drive_window(32'h0, t, 0);
      wait_valid(lat);
      checks++;
      if (lat !== 0) begin
         errors++; $display("FAIL b2b_latency got %0d want 0 extra cycles", lat);
      end
      e = sb_q.pop_front();
      checks++;
      if (out_data_r !== e.relu || out_data_w !== e.raw) begin
         errors++; $display("FAIL b2b_sum got %h/%h want %h/%h", out_data_r, out_data_w, e.relu, e.raw);
      end
      checks++;
      if (in_ready_r !== 1'b0 || busy_r !== 1'b1) begin
         errors++; $display("FAIL b2b_out_state got in_ready=%b busy=%b want 0 1", in_ready_r, busy_r);
      end
      handshake();
      checks++;
      if (out_valid_r !== 1'b0 || in_ready_r !== 1'b1 || busy_r !== 1'b0) begin
         errors++; $display("FAIL b2b_release got v=%b r=%b busy=%b want 0 1 0", out_valid_r, in_ready_r, busy_r);
      end
   endtask

   task automatic test_gaps();
      logic [31:0] t [4];
      exp_t e;
      int lat;
      t = '{32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000};
      sb_q.push_back('{relu: 32'h4090_0000, raw: 32'h4090_0000});
      drive_window(32'h3F00_0000, t, 2);
      wait_valid(lat);
      e = sb_q.pop_front();
      checks++;
      if (lat !== 0 || out_data_r !== e.relu || out_data_w !== e.raw) begin
         errors++; $display("FAIL gaps_sum got lat=%0d %h/%h want 0 %h/%h", lat, out_data_r, out_data_w, e.relu, e.raw);
      end
      handshake();
   endtask

   task automatic test_negative();
      logic [31:0] t [4];
      exp_t e;
      int lat;
      t = '{32'hBF80_0000, 32'hC000_0000, 32'hC040_0000, 32'hC080_0000};
      sb_q.push_back('{relu: 32'h0000_0000, raw: 32'hC120_0000});
      drive_window(32'h0, t, 0);
      wait_valid(lat);
      e = sb_q.pop_front();
      checks++;
      if (lat !== 0 || out_data_r !== e.relu) begin
         errors++; $display("FAIL neg_relu got lat=%0d %h want 0 %h", lat, out_data_r, e.relu);
      end
      checks++;
      if (out_data_w !== e.raw) begin
         errors++; $display("FAIL neg_raw got %h want %h", out_data_w, e.raw);
      end
      handshake();
   endtask

   task automatic test_cancel();
      logic [31:0] t [4];
      exp_t e;
      int lat;
      t = '{32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000, 32'h4000_0000};
      sb_q.push_back('{relu: 32'h4000_0000, raw: 32'h4000_0000});
      drive_window(32'h0, t, 0);
      wait_valid(lat);
      e = sb_q.pop_front();
      checks++;
      if (lat !== 0 || out_data_r !== e.relu || out_data_w !== e.raw) begin
         errors++; $display("FAIL cancel_sum got lat=%0d %h/%h want 0 %h/%h", lat, out_data_r, out_data_w, e.relu, e.raw);
      end
      handshake();
   endtask

   task automatic test_backpressure();
      logic [31:0] t [4];
      exp_t e;
      int lat;
      t = '{int_to_fp(5), int_to_fp(6), int_to_fp(7), int_to_fp(8)};
      sb_q.push_back('{relu: 32'h41D8_0000, raw: 32'h41D8_0000});
      drive_window(int_to_fp(1), t, 0);
      wait_valid(lat);
      e = sb_q.pop_front();
      in_valid = 1'b1;
      in_data  = 32'h4700_0000;
      for (int c = 0; c < 5; c++) begin
         checks++;
         if (out_valid_r !== 1'b1 || in_ready_r !== 1'b0 || out_data_r !== e.relu) begin
            errors++; $display("FAIL bp_hold[%0d] got v=%b r=%b d=%h want 1 0 %h", c, out_valid_r, in_ready_r, out_data_r, e.relu);
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
      handshake();
      checks++;
      if (out_valid_r !== 1'b0 || in_ready_r !== 1'b1) begin
         errors++; $display("FAIL bp_release got v=%b r=%b want 0 1", out_valid_r, in_ready_r);
      end
      t = '{int_to_fp(1), int_to_fp(1), int_to_fp(1), int_to_fp(1)};
      sb_q.push_back('{relu: 32'h4080_0000, raw: 32'h4080_0000});
      drive_window(32'h0, t, 0);
      wait_valid(lat);
      e = sb_q.pop_front();
      checks++;
      if (lat !== 0 || out_data_r !== e.relu || out_data_w !== e.raw) begin
         errors++; $display("FAIL bp_next_window got lat=%0d %h/%h want 0 %h/%h", lat, out_data_r, out_data_w, e.relu, e.raw);
      end
      handshake();
   endtask

   task automatic test_reset_mid();
      logic [31:0] t [4];
      exp_t e;
      int lat;
      bias     = int_to_fp(10);
      in_valid = 1'b1;
      in_data  = int_to_fp(5);
      repeat (2) @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (busy_r !== 1'b1 || out_valid_r !== 1'b0) begin
         errors++; $display("FAIL mid_busy got busy=%b v=%b want 1 0", busy_r, out_valid_r);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if (out_valid_r !== 1'b0 || busy_r !== 1'b0 || out_data_r !== 32'h0 || in_ready_r !== 1'b0) begin
         errors++; $display("FAIL mid_reset got v=%b busy=%b d=%h r=%b want 0 0 0 0", out_valid_r, busy_r, out_data_r, in_ready_r);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      t = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000};
      sb_q.push_back('{relu: 32'h4120_0000, raw: 32'h4120_0000});
      drive_window(32'h0, t, 0);
      wait_valid(lat);
      e = sb_q.pop_front();
      checks++;
      if (lat !== 0 || out_data_r !== e.relu || out_data_w !== e.raw) begin
         errors++; $display("FAIL mid_fresh_window got lat=%0d %h/%h want 0 %h/%h", lat, out_data_r, out_data_w, e.relu, e.raw);
      end
      handshake();
   endtask

   task automatic test_single_term();
      bias      = int_to_fp(3);
      in_data   = int_to_fp(2);
      in_valid1 = 1'b1;
      @(negedge clk);
      in_valid1 = 1'b0;
      bias      = 32'h0;
      checks++;
      if (out_valid_1 !== 1'b1 || out_data_1 !== 32'h40A0_0000 || in_ready_1 !== 1'b0) begin
         errors++; $display("FAIL single_term got v=%b d=%h r=%b want 1 40a00000 0", out_valid_1, out_data_1, in_ready_1);
      end
      out_ready1 = 1'b1;
      @(negedge clk);
      out_ready1 = 1'b0;
      checks++;
      if (out_valid_1 !== 1'b0 || busy_1 !== 1'b0 || in_ready_1 !== 1'b1) begin
         errors++; $display("FAIL single_release got v=%b busy=%b r=%b want 0 0 1", out_valid_1, busy_1, in_ready_1);
      end
   endtask

   task automatic test_random_windows();
      logic [31:0] t [4];
      exp_t e;
      int lat, b, v, s;
      for (int w = 0; w < 8; w++) begin
         b = $urandom_range(200) - 100;
         s = b;
         for (int k = 0; k < 4; k++) begin
            v = $urandom_range(80) - 40;
            if (k == 1 && w == 3) v = -(b + 1);
            s += v;
            t[k] = int_to_fp(v);
         end
         sb_q.push_back('{relu: (s < 0) ? 32'h0 : int_to_fp(s), raw: int_to_fp(s)});
         drive_window(int_to_fp(b), t, w % 2);
         wait_valid(lat);
         e = sb_q.pop_front();
         checks++;
         if (lat !== 0 || out_data_r !== e.relu || out_data_w !== e.raw) begin
            errors++; $display("FAIL rand_window[%0d] got lat=%0d %h/%h want 0 %h/%h", w, lat, out_data_r, out_data_w, e.relu, e.raw);
         end
         handshake();
      end
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_gaps();
      test_negative();
      test_cancel();
      test_backpressure();
      test_reset_mid();
      test_single_term();
      test_random_windows();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got no finish want finish");
      $fatal(1, "timeout");
   end
endmodule
